mealy_101_detector: RTL and testbench
=====================================

// Module: mealy_101_detector
// PURPOSE
//  Mealy-type serial detector for the bit pattern 1-0-1 on a 1-bit input stream sampled every clk.
//  det asserts combinationally in the same cycle the final '1' is present on I, i.e. before the capturing edge.
//  Standalone leaf block feeding framing/sync logic; no handshake, one input bit per cycle.
// PARAMETERS
//  OVERLAP  1  1: overlapping detection (101 tail '1' starts next match); 0: non-overlapping (restart from IDLE after match)
//  CNT_W    8  width of match counter; used only when MEALY_101_CNT_EN defined
// PORTS
//  clk      in   1      single clock, all state updates on posedge
//  rst      in   1      synchronous, active-high reset
//  I        in   1      serial data bit, sampled on posedge clk
//  det      out  1      Mealy match flag, high while state==S10 && I==1 && !rst
//  det_cnt  out  CNT_W  number of matches since reset (present only with MEALY_101_CNT_EN)
// BEHAVIOUR
//  - One clock (clk); reset rst is synchronous, active-high: state <= S_IDLE on posedge clk when rst=1.
//  - States (2-bit encoding): S_IDLE=0 (no prefix), S_1=1 (seen "1"), S_10=2 (seen "10"); code 3 illegal -> S_IDLE next.
//  - Transitions (rst=0): S_IDLE: I=1->S_1, I=0->S_IDLE; S_1: I=1->S_1, I=0->S_10;
//    S_10: I=1->S_1 if OVERLAP=1 else S_IDLE, I=0->S_IDLE.
//  - det = (state==S_10) & I & ~rst; purely combinational from registered state and live I, zero-cycle latency.
//  - det is one cycle wide per match unless I glitches; it follows I within S_10 asynchronously.
//  - Reset value: state S_IDLE, det=0 (forced low while rst=1 regardless of state/I), det_cnt=0.
//  - Before first reset state is undefined; det may be X; no requirement.
//  - Reset mid-pattern: prefix discarded; "10" then rst then "1" must not detect.
//  - Back-to-back "10101": OVERLAP=1 -> 2 matches; OVERLAP=0 -> 1 match.
// CONFIGURATION
//  - MEALY_101_CNT_EN defined: det_cnt port exists; increments by 1 on each posedge where det=1;
//    saturates at 2**CNT_W-1 (no wrap); cleared by rst (rst takes priority over increment).
//  - MEALY_101_CNT_EN undefined: no det_cnt port, no counter logic; CNT_W ignored.
// STRUCTURE
//  - Package mealy_101_pkg: state typedef (2-bit enum S_IDLE/S_1/S_10) and state-width constant.
//  - Top: one state register always block, one next-state/output combinational block.
//  - Optional sub-module mealy_101_sat_counter (CNT_W, clk, rst, inc, cnt) instantiated only under MEALY_101_CNT_EN.
// TESTING
//  - clk period 10, I=0 at reset; rst=1 for one edge then 0; I = 1,1,0,1,1,0,1,0 one bit per cycle
//    -> det high exactly on 4th and 7th bits (two pulses), 0 elsewhere; det_cnt=2 at end (CNT_EN).
//  - OVERLAP=0, I = 1,0,1,0,1 -> det only on 3rd bit; OVERLAP=1 -> det on 3rd and 5th bits.
//  - I = 1,0 then rst=1 one cycle with I=1 -> det=0 during rst; next I=1 after reset -> det=0.
//  - Constant I=1 for 20 cycles, then constant I=0 for 20 cycles -> det never asserts.
//  - CNT_EN, CNT_W=2: 5 matches with OVERLAP=1 -> det_cnt saturates at 3; rst -> det_cnt=0 next edge.
//  - In S_10 toggle I 0->1->0 within one cycle -> det follows I combinationally, state still updates only at posedge.

Source files
------------

// File: rtl/mealy_101_pkg.sv
// Shared types for the 1-0-1 serial pattern detector.
// The state encoding is fixed at 2 bits; code 3 is illegal and recovers to S_IDLE.
package mealy_101_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 2'd0,
        S_1    = 2'd1,
        S_10   = 2'd2
    } state_t;

endpackage

// File: rtl/mealy_101_detector_if.sv
// Serial bit stream in, match flag out; det_cnt exists only when MEALY_101_CNT_EN is defined.
interface mealy_101_detector_if #(
    parameter int CNT_W = 8
);
    logic I;
    logic det;
`ifdef MEALY_101_CNT_EN
    logic [CNT_W-1:0] det_cnt;

    modport master (output I, input det, input det_cnt);
    modport slave (input I, output det, output det_cnt);
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;

    modport master (output I, input det);
    modport slave (input I, output det);
`endif
endinterface

// File: rtl/mealy_101_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping, rst wins over inc.
module mealy_101_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/mealy_101_detector.sv
// Mealy detector for 1-0-1 on a serial bit stream; det is combinational from state and live I.
// Optional match counter is built only when MEALY_101_CNT_EN is defined.
module mealy_101_detector
    import mealy_101_pkg::*;
#(
    parameter bit OVERLAP = 1'b1,
    parameter int CNT_W   = 8
) (
    input logic                 clk,
    input logic                 rst,
    mealy_101_detector_if.slave bus
);
    state_t state;
    state_t state_nxt;
    logic   det_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S_IDLE;
        det_w     = 1'b0;
        case (state)
            S_IDLE: state_nxt = bus.I ? S_1 : S_IDLE;
            S_1:    state_nxt = bus.I ? S_1 : S_10;
            S_10: begin
                // rst masks det so a reset cycle never reports a stale prefix
                det_w = bus.I & ~rst;
                if (bus.I) begin
                    state_nxt = OVERLAP ? S_1 : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.det = det_w;

`ifdef MEALY_101_CNT_EN
    mealy_101_sat_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (det_w),
        .cnt (bus.det_cnt)
    );
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif
endmodule

// File: tb/tb_mealy_101_detector.sv
// Bench for mealy_101_detector: an overlapping and a non-overlapping instance share stimulus
// and are compared against a bit-history reference model; det_cnt checked when MEALY_101_CNT_EN.
module tb_mealy_101_detector;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    bit hist1[$];
    bit hist0[$];
    int cnt1 = 0;
    int cnt0 = 0;

    mealy_101_detector_if #(.CNT_W(CNT_W)) bus1 ();
    mealy_101_detector_if #(.CNT_W(CNT_W)) bus0 ();

    mealy_101_detector #(.OVERLAP(1'b1), .CNT_W(CNT_W)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    mealy_101_detector #(.OVERLAP(1'b0), .CNT_W(CNT_W)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Match rule: the current bit is 1 and the bits seen since the last restart end in "10".
    function automatic bit model_det(input int which, input bit i, input bit r);
        int n;
        if (r || !i) return 1'b0;
        if (which == 1) begin
            n = hist1.size();
            return (n >= 2) && hist1[n-2] && !hist1[n-1];
        end
        n = hist0.size();
        return (n >= 2) && hist0[n-2] && !hist0[n-1];
    endfunction

    function automatic int sat_inc(input int c);
        return (c >= (1 << CNT_W) - 1) ? c : c + 1;
    endfunction

    // One cycle: drive after the previous edge, check mid-cycle, advance the model at the edge.
    // exp1/exp0 < 0 means no directed expectation beyond the model.
    task automatic step(input bit i, input bit r, input int exp1, input int exp0);
        bit m1;
        bit m0;
        bus1.I = i;
        bus0.I = i;
        rst    = r;
        #2;
        m1 = model_det(1, i, r);
        m0 = model_det(0, i, r);
        chk("det_ov1_model", bus1.det, m1);
        chk("det_ov0_model", bus0.det, m0);
        if (exp1 >= 0) chk("det_ov1_directed", bus1.det, exp1);
        if (exp0 >= 0) chk("det_ov0_directed", bus0.det, exp0);
`ifdef MEALY_101_CNT_EN
        chk("cnt_ov1_model", bus1.det_cnt, cnt1);
        chk("cnt_ov0_model", bus0.det_cnt, cnt0);
`endif
        @(posedge clk);
        if (r) begin
            hist1.delete();
            hist0.delete();
            cnt1 = 0;
            cnt0 = 0;
        end else begin
            if (m1) cnt1 = sat_inc(cnt1);
            if (m0) cnt0 = sat_inc(cnt0);
            hist1.push_back(i);
            hist0.push_back(i);
            if (m0) hist0.delete();
            if (hist1.size() > 2) void'(hist1.pop_front());
            if (hist0.size() > 2) void'(hist0.pop_front());
        end
        #1;
    endtask

    task automatic run_seq(input bit bits[], input int e1[], input int e0[]);
        foreach (bits[k]) step(bits[k], 1'b0, e1[k], e0[k]);
    endtask

    initial begin
        bus1.I = 1'b0;
        bus0.I = 1'b0;

        // Reset, then the two-pulse sequence 1,1,0,1,1,0,1,0
        step(1'b0, 1'b1, 0, 0);
        run_seq('{1, 1, 0, 1, 1, 0, 1, 0},
                '{0, 0, 0, 1, 0, 0, 1, 0},
                '{0, 0, 0, 1, 0, 0, 1, 0});
`ifdef MEALY_101_CNT_EN
        #2;
        chk("cnt_two_pulses", bus1.det_cnt, 2);
        #0;
`endif

        // Back-to-back 10101: overlap gives two matches, non-overlap one
        step(1'b0, 1'b1, 0, 0);
        run_seq('{1, 0, 1, 0, 1},
                '{0, 0, 1, 0, 1},
                '{0, 0, 1, 0, 0});

        // Reset in the middle of a prefix discards it
        step(1'b0, 1'b1, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b1, 0, 0);
        step(1'b1, 1'b0, 0, 0);

        // Constant runs never match
        step(1'b0, 1'b1, 0, 0);
        for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 0, 0);
        for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 0, 0);

        // Glitching I inside S_10: det follows I, state only moves at the edge
        step(1'b0, 1'b1, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        bus1.I = 1'b0; bus0.I = 1'b0;
        #1;
        chk("glitch_low_a", {bus1.det, bus0.det}, 2'b00);
        bus1.I = 1'b1; bus0.I = 1'b1;
        #1;
        chk("glitch_high", {bus1.det, bus0.det}, 2'b11);
        bus1.I = 1'b0; bus0.I = 1'b0;
        #1;
        chk("glitch_low_b", {bus1.det, bus0.det}, 2'b00);
        @(posedge clk);
        #1;
        hist1.delete(); hist1.push_back(1'b1); hist1.push_back(1'b0); hist1.push_back(1'b0);
        hist0.delete(); hist0.push_back(1'b1); hist0.push_back(1'b0); hist0.push_back(1'b0);
        void'(hist1.pop_front());
        void'(hist0.pop_front());
        step(1'b1, 1'b0, 0, 0);

`ifdef MEALY_101_CNT_EN
        // Five overlapping matches saturate a 2-bit counter at 3, reset clears it
        step(1'b0, 1'b1, 0, 0);
        run_seq('{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1},
                '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1},
                '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1});
        #2;
        chk("cnt_saturated", bus1.det_cnt, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("cnt_cleared", bus1.det_cnt, 0);
        hist1.delete(); hist0.delete(); cnt1 = 0; cnt0 = 0;
`endif

        // Random traffic with occasional resets
        step(1'b0, 1'b1, -1, -1);
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
